sio_dmu_pkt_tracker: RTL
========================

Name: sio_dmu_pkt_tracker

Overview:
- Parametrised SIU-to-DMU outbound packet tracker/checker on the iol2clk domain; sits passively on sio_dmu_hdr_vld/datareq/data/parity.
- Frames header and payload cycles with an FSM, captures the header, and checks per-lane parity on every payload beat.
- Flags protocol violations with sticky error bits and keeps saturating packet/beat statistics for bench scoreboards.
- Generalises width, beat count, header-to-payload gap and parity sense; adds reset, enable gating and checking.

Parameters:
- DW, 128, data bus width in bits.
- PW, 8, parity bits; lane width = DW/PW, DW must be divisible by PW.
- BEATS, 4, payload beats per data-carrying packet (>=1).
- GAP, 1, idle cycles between header cycle and first payload beat (0..15).
- ODD_PAR, 0, 0 = even parity per lane, 1 = odd.
- CW, 16, statistics counter width.

Ports:
- iol2clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  tracking enable; when low, FSM forced to IDLE next edge, nothing counted.
- err_clr  in  1  synchronous clear of all sticky error bits.
- sio_dmu_hdr_vld  in  1  header cycle valid.
- sio_dmu_datareq  in  1  qualifies header: payload follows.
- sio_dmu_data  in  DW  header/payload bus.
- sio_dmu_parity  in  PW  per-lane parity.
- hdr_q  out  DW  last captured header.
- hdr_has_data  out  1  datareq value captured with hdr_q.
- in_payload  out  1  current cycle is a payload beat.
- beat_idx  out  clog2(BEATS)+1  index of current payload beat.
- pkt_done  out  1  one-cycle pulse at packet completion.
- pkt_cnt  out  CW  completed packets (saturating).
- beat_cnt  out  CW  payload beats checked (saturating).
- err_par  out  1  sticky: parity mismatch on a payload beat.
- err_par_lane  out  PW  sticky OR of failing lanes.
- err_overlap  out  1  sticky: hdr_vld while in GAP or PAYLOAD.
- err_orphan  out  1  sticky: datareq high without hdr_vld in IDLE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; hdr_q=0, hdr_has_data=0, in_payload=0, beat_idx=0, pkt_done=0, pkt_cnt=0, beat_cnt=0, all err_*=0.
- States: IDLE, GAP, PAYLOAD.
- IDLE + enable + hdr_vld: capture hdr_q<=data, hdr_has_data<=datareq. If datareq=0: pkt_done=1 next cycle, pkt_cnt++, stay IDLE. If datareq=1: GAP>0 -> GAP with gap counter=GAP; GAP=0 -> PAYLOAD with beat_idx=0.
- GAP: counter decrements each cycle; at 1 -> PAYLOAD. With GAP=1, the first beat is the cycle after the one following the header (header at T, beat0 at T+2).
- PAYLOAD: in_payload is a combinational decode of state. Each cycle checks lanes: lane i fails if XOR(data lane i) ^ parity[i] != ODD_PAR. beat_cnt++ per beat. Last beat (beat_idx=BEATS-1) -> IDLE, pkt_done pulse registered the following cycle, pkt_cnt++.
- hdr_vld in GAP/PAYLOAD: err_overlap<=1; hdr_q is not updated and the current packet continues unaffected.
- IDLE, hdr_vld=0, datareq=1: err_orphan<=1.
- Header cycle carries no parity check.
- Header-only packet, followed by hdr_vld on the next cycle: both packets are accepted back to back.
- Completion of a data packet followed by a new header on the cycle after the last beat: accepted, no error.
- Counters saturate at all-ones and do not wrap.
- err_clr together with a new error in the same cycle: the new error wins (bit stays 1).
- enable deassert mid-packet: FSM->IDLE next edge; the packet is dropped uncounted and no error is raised. Statistics and sticky bits are held.
- rst mid-packet: immediate return to reset values.

Test Plan:
- Header-only packet: hdr_vld=1, datareq=0, data=0xA5..A5 -> hdr_q=0xA5..A5, pkt_done pulse at T+1, pkt_cnt=1, beat_cnt=0, no errors.
- Data packet, defaults, correct even parity: header T, beats T+2..T+5 -> in_payload=1 for exactly 4 cycles, beat_idx 0..3, pkt_cnt=1, beat_cnt=4.
- Beat 2 with lane 5 parity flipped -> err_par=1, err_par_lane=8'h20; packet still completes; err_clr clears both.
- hdr_vld during beat 1 -> err_overlap=1, hdr_q unchanged, packet completes after 4 beats, pkt_cnt increments by 1.
- datareq=1 alone in IDLE -> err_orphan=1; then rst asserted during PAYLOAD -> all outputs 0 immediately.
- Instance BEATS=8, GAP=0, ODD_PAR=1, DW=256, PW=16: beats start at T+1, 8 beats, odd parity passes, beat_cnt=8.

Source files
------------

// File: rtl/sio_dmu_pkt_tracker.sv
// Passive tracker for SIU-to-DMU outbound packets: frames header/gap/payload cycles,
// checks per-lane parity on payload beats, keeps sticky errors and saturating stats.
module sio_dmu_pkt_tracker #(
  parameter int DW      = 128,
  parameter int PW      = 8,
  parameter int BEATS   = 4,
  parameter int GAP     = 1,
  parameter int ODD_PAR = 0,
  parameter int CW      = 16
) (
  input  logic                     iol2clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     err_clr,
  input  logic                     sio_dmu_hdr_vld,
  input  logic                     sio_dmu_datareq,
  input  logic [DW-1:0]            sio_dmu_data,
  input  logic [PW-1:0]            sio_dmu_parity,
  output logic [DW-1:0]            hdr_q,
  output logic                     hdr_has_data,
  output logic                     in_payload,
  output logic [$clog2(BEATS):0]   beat_idx,
  output logic                     pkt_done,
  output logic [CW-1:0]            pkt_cnt,
  output logic [CW-1:0]            beat_cnt,
  output logic                     err_par,
  output logic [PW-1:0]            err_par_lane,
  output logic                     err_overlap,
  output logic                     err_orphan
);

  localparam int LW  = DW / PW;
  localparam int BIW = $clog2(BEATS) + 1;
  localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);
  localparam logic [3:0]     GAP_INIT  = 4'(GAP);
  localparam logic           ODD_BIT   = (ODD_PAR != 0);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_PAYLOAD} state_t;

  state_t          state_q, state_d;
  logic [3:0]      gap_q, gap_d;
  logic [BIW-1:0]  beat_idx_q, beat_idx_d;
  logic [DW-1:0]   hdr_d;
  logic            has_data_q, has_data_d;
  logic            pkt_done_q, pkt_done_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_par_q, err_par_d;
  logic [PW-1:0]   err_lane_q, err_lane_d;
  logic            err_ov_q, err_ov_d;
  logic            err_orph_q, err_orph_d;

  logic [PW-1:0]   lane_fail;
  logic            pkt_inc, beat_inc, par_new, ov_new, orph_new;

  // A lane fails when its data XOR parity disagrees with the selected parity sense
  always_comb begin
    lane_fail = '0;
    for (int i = 0; i < PW; i++) begin
      lane_fail[i] = (^sio_dmu_data[i*LW +: LW]) ^ sio_dmu_parity[i] ^ ODD_BIT;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    beat_idx_d = beat_idx_q;
    hdr_d      = hdr_q;
    has_data_d = has_data_q;
    pkt_done_d = 1'b0;
    pkt_inc    = 1'b0;
    beat_inc   = 1'b0;
    par_new    = 1'b0;
    ov_new     = 1'b0;
    orph_new   = 1'b0;

    if (!enable) begin
      state_d    = S_IDLE;
      gap_d      = '0;
      beat_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sio_dmu_hdr_vld) begin
            hdr_d      = sio_dmu_data;
            has_data_d = sio_dmu_datareq;
            if (!sio_dmu_datareq) begin
              pkt_done_d = 1'b1;
              pkt_inc    = 1'b1;
            end else if (GAP == 0) begin
              state_d    = S_PAYLOAD;
              beat_idx_d = '0;
            end else begin
              state_d = S_GAP;
              gap_d   = GAP_INIT;
            end
          end else if (sio_dmu_datareq) begin
            orph_new = 1'b1;
          end
        end
        S_GAP: begin
          ov_new = sio_dmu_hdr_vld;
          if (gap_q == 4'd1) begin
            state_d    = S_PAYLOAD;
            gap_d      = '0;
            beat_idx_d = '0;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        S_PAYLOAD: begin
          ov_new   = sio_dmu_hdr_vld;
          beat_inc = 1'b1;
          par_new  = |lane_fail;
          if (beat_idx_q == LAST_BEAT) begin
            state_d    = S_IDLE;
            beat_idx_d = '0;
            pkt_done_d = 1'b1;
            pkt_inc    = 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + BIW'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          gap_d      = '0;
          beat_idx_d = '0;
        end
      endcase
    end
  end

  // Counters stick at all-ones; a fresh error outranks a simultaneous clear
  always_comb begin
    pkt_cnt_d  = (pkt_inc && (pkt_cnt_q != '1)) ? pkt_cnt_q + CW'(1) : pkt_cnt_q;
    beat_cnt_d = (beat_inc && (beat_cnt_q != '1)) ? beat_cnt_q + CW'(1) : beat_cnt_q;
    err_par_d  = (err_par_q & ~err_clr) | par_new;
    err_lane_d = (err_lane_q & ~{PW{err_clr}}) | (par_new ? lane_fail : '0);
    err_ov_d   = (err_ov_q & ~err_clr) | ov_new;
    err_orph_d = (err_orph_q & ~err_clr) | orph_new;
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      beat_idx_q <= '0;
      hdr_q      <= '0;
      has_data_q <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      err_par_q  <= 1'b0;
      err_lane_q <= '0;
      err_ov_q   <= 1'b0;
      err_orph_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      beat_idx_q <= beat_idx_d;
      hdr_q      <= hdr_d;
      has_data_q <= has_data_d;
      pkt_done_q <= pkt_done_d;
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_par_q  <= err_par_d;
      err_lane_q <= err_lane_d;
      err_ov_q   <= err_ov_d;
      err_orph_q <= err_orph_d;
    end
  end

  assign hdr_has_data = has_data_q;
  assign in_payload   = (state_q == S_PAYLOAD);
  assign beat_idx     = beat_idx_q;
  assign pkt_done     = pkt_done_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign beat_cnt     = beat_cnt_q;
  assign err_par      = err_par_q;
  assign err_par_lane = err_lane_q;
  assign err_overlap  = err_ov_q;
  assign err_orphan   = err_orph_q;

endmodule
